// File: rtl/trace_chk_pkg.sv
// trace_chk_pkg: shared encodings for the CPU commit-trace checker.
//   - trace entry types (3-bit ref_type field)
//   - error codes reported on err_code (first error wins)
//   - checker state encoding
package trace_chk_pkg;

    typedef enum logic [2:0] {
        TR_END = 3'd0,   // end of trace
        TR_RF  = 3'd1,   // register-file write (or plain commit when addr==0)
        TR_MEM = 3'd2,   // memory write
        TR_BR  = 3'd3,   // branch, carries expected next PC
        TR_JAL = 3'd4    // jump-and-link, carries link data and next PC
    } trace_type_e;

    typedef enum logic [3:0] {
        ERR_NONE      = 4'd0,
        ERR_PC        = 4'd1,
        ERR_FLAGS     = 4'd2,
        ERR_RF        = 4'd3,
        ERR_MEM       = 4'd4,
        ERR_JAL       = 4'd5,
        ERR_TARGET    = 4'd6,
        ERR_TIMEOUT   = 4'd7,
        ERR_UNDERFLOW = 4'd8,
        ERR_BADTYPE   = 4'd9
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

endpackage

// File: rtl/trace_chk_fifo.sv
// trace_chk_fifo: synchronous FIFO holding packed reference trace entries.
// Ports:
//   i_clk, i_resetn   clock, async active-low reset
//   i_clr             synchronous flush (empties the FIFO)
//   i_push, i_data    write request / entry; accepted when not full, or when
//                     full and a pop happens in the same cycle
//   i_pop             read request; ignored when empty
//   o_data            head entry (valid when !o_empty)
//   o_full, o_empty   occupancy flags
module trace_chk_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [PW-1:0]    r_wptr, r_rptr;
    logic             w_do_push, w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_clr) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/cpu_trace_checker.sv
// cpu_trace_checker: compares CPU commit signals against a reference trace.
// Reference entries arrive on a valid/ready stream into a prefetch FIFO; each
// retiring instruction is checked against the FIFO head. Status (pass/fail,
// first error code/PC, commit and error counters) is registered, so it
// reflects a commit one cycle after that commit.
// Ports:
//   clk, resetn          clock, async active-low reset
//   start                pulse: enter RUN, clear counters/status/FIFO
//                        (restart is honoured from any state)
//   ref_*                reference entry stream (ref_ready = room in FIFO)
//   commit_*             CPU commit interface, one retire per commit_valid
//   busy/pass/fail       RUN state / clean end-of-trace / error seen
//   err_code, err_pc     first error code and commit PC (0 for timeout)
//   commit_cnt, err_cnt  saturating counters
// Build option: TRACE_CHK_CONTINUE_EN keeps checking after an error (only
// a timeout is terminal); otherwise the first error stops the checker.
module cpu_trace_checker
    import trace_chk_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int RF_AW       = 5,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              ref_valid,
    output logic              ref_ready,
    input  logic [2:0]        ref_type,
    input  logic [XLEN-1:0]   ref_pc,
    input  logic [XLEN-1:0]   ref_addr,
    input  logic [XLEN-1:0]   ref_data,
    input  logic [XLEN-1:0]   ref_mask,
    input  logic [XLEN/8-1:0] ref_strb,
    input  logic [XLEN-1:0]   ref_new_pc,
    input  logic              ref_mem_read,
    input  logic              commit_valid,
    input  logic [XLEN-1:0]   commit_pc,
    input  logic              commit_rf_wen,
    input  logic [RF_AW-1:0]  commit_rf_waddr,
    input  logic [XLEN-1:0]   commit_rf_wdata,
    input  logic              commit_mem_wen,
    input  logic              commit_mem_read,
    input  logic [XLEN-1:0]   commit_mem_addr,
    input  logic [XLEN/8-1:0] commit_mem_wstrb,
    input  logic [XLEN-1:0]   commit_mem_wdata,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [3:0]        err_code,
    output logic [XLEN-1:0]   err_pc,
    output logic [CNT_W-1:0]  commit_cnt,
    output logic [CNT_W-1:0]  err_cnt
);
    localparam int SW   = XLEN / 8;
    localparam int EW   = 3 + 5 * XLEN + SW + 1;
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    state_e           r_state;
    logic             r_pass, r_fail;
    logic [3:0]       r_err_code;
    logic [XLEN-1:0]  r_err_pc, r_exp_pc;
    logic             r_exp_pc_vld;
    logic [CNT_W-1:0] r_commit_cnt, r_err_cnt;
    logic [WD_W-1:0]  r_wdog;

    logic [EW-1:0]    w_push_data, w_head;
    logic             w_full, w_empty, w_push, w_pop;
    logic [2:0]       w_h_type;
    logic [XLEN-1:0]  w_h_pc, w_h_addr, w_h_data, w_h_mask, w_h_new_pc;
    logic [SW-1:0]    w_h_strb;
    logic             w_h_mr;
    logic             w_run, w_head_end, w_head_bad, w_chk, w_underflow, w_timeout, w_err;
    logic [2:0]       w_flags;
    logic [RF_AW-1:0] w_raddr;
    logic             w_flag_bad, w_rf_bad, w_mem_bad, w_jal_bad;
    logic [3:0]       w_chk_code, w_ev_code;
    logic [XLEN-1:0]  w_ev_pc;

    assign w_push_data = {ref_type, ref_pc, ref_addr, ref_data, ref_mask, ref_strb, ref_new_pc, ref_mem_read};
    assign {w_h_type, w_h_pc, w_h_addr, w_h_data, w_h_mask, w_h_strb, w_h_new_pc, w_h_mr} = w_head;

    assign w_run      = (r_state == ST_RUN);
    assign w_head_end = w_run && !w_empty && (w_h_type == TR_END);
    assign w_head_bad = w_run && !w_empty && (w_h_type > TR_JAL);
    assign w_chk       = w_run && commit_valid && !w_empty && !w_head_end && !w_head_bad;
    assign w_underflow = w_run && commit_valid && w_empty;
    // Timeout yields to head events so an arriving end/bad entry is not masked.
    assign w_timeout   = w_run && !commit_valid && !w_head_end && !w_head_bad &&
                         (r_wdog == WD_W'(TIMEOUT_CYC - 1));

    // End and bad heads are consumed on their own; data heads need a commit.
    assign w_pop     = w_head_end || w_head_bad || w_chk;
    assign ref_ready = w_run && (!w_full || w_pop);
    assign w_push    = ref_valid && ref_ready;

    trace_chk_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk    (clk),
        .i_resetn (resetn),
        .i_clr    (start),
        .i_push   (w_push),
        .i_data   (w_push_data),
        .i_pop    (w_pop),
        .o_data   (w_head),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    assign w_flags = {commit_mem_wen, commit_rf_wen, commit_mem_read};
    assign w_raddr = w_h_addr[RF_AW-1:0];

    always_comb begin
        w_flag_bad = 1'b0;
        case (w_h_type)
            TR_RF:   w_flag_bad = commit_mem_wen;
            TR_MEM:  w_flag_bad = (w_flags != 3'b100);
            TR_BR:   w_flag_bad = (w_flags != 3'b000);
            TR_JAL:  w_flag_bad = (w_flags != 3'b010);
            default: w_flag_bad = 1'b0;
        endcase
        // x0 entries: the CPU may or may not drive a dead write to x0.
        if (w_raddr != '0)
            w_rf_bad = !commit_rf_wen || (commit_mem_read != w_h_mr) ||
                       (commit_rf_waddr != w_raddr) ||
                       ((commit_rf_wdata & w_h_mask) != (w_h_data & w_h_mask));
        else
            w_rf_bad = (commit_rf_wen && commit_rf_waddr != '0) || (!w_h_mr && commit_mem_read);
        w_mem_bad = (commit_mem_addr != w_h_addr) || (commit_mem_wstrb != w_h_strb) ||
                    ((commit_mem_wdata & w_h_mask) != (w_h_data & w_h_mask));
        w_jal_bad = (commit_rf_waddr != w_raddr) || (commit_rf_wdata != w_h_data);

        w_chk_code = ERR_NONE;
        if (commit_pc != w_h_pc)                        w_chk_code = ERR_PC;
        else if (r_exp_pc_vld && commit_pc != r_exp_pc) w_chk_code = ERR_TARGET;
        else if (w_flag_bad)                            w_chk_code = ERR_FLAGS;
        else if (w_h_type == TR_RF  && w_rf_bad)        w_chk_code = ERR_RF;
        else if (w_h_type == TR_MEM && w_mem_bad)       w_chk_code = ERR_MEM;
        else if (w_h_type == TR_JAL && w_jal_bad)       w_chk_code = ERR_JAL;

        w_ev_code = ERR_NONE;
        if (w_head_bad)       w_ev_code = ERR_BADTYPE;
        else if (w_chk)       w_ev_code = w_chk_code;
        else if (w_underflow) w_ev_code = ERR_UNDERFLOW;
        else if (w_timeout)   w_ev_code = ERR_TIMEOUT;
        w_ev_pc = (commit_valid && !w_timeout) ? commit_pc : '0;
    end

    assign w_err = (w_ev_code != ERR_NONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
            r_err_code   <= '0;
            r_err_pc     <= '0;
            r_exp_pc     <= '0;
            r_exp_pc_vld <= 1'b0;
            r_commit_cnt <= '0;
            r_err_cnt    <= '0;
            r_wdog       <= '0;
        end else if (start) begin
            r_state      <= ST_RUN;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
            r_err_code   <= '0;
            r_err_pc     <= '0;
            r_exp_pc_vld <= 1'b0;
            r_commit_cnt <= '0;
            r_err_cnt    <= '0;
            r_wdog       <= '0;
        end else if (w_run) begin
            r_wdog <= commit_valid ? '0 : r_wdog + WD_W'(1);
            if (w_chk) begin
                if (r_commit_cnt != '1) r_commit_cnt <= r_commit_cnt + CNT_W'(1);
                r_exp_pc_vld <= (w_h_type == TR_BR) || (w_h_type == TR_JAL);
                r_exp_pc     <= w_h_new_pc;
            end
            if (w_err) begin
                if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
                if (!r_fail) begin
                    r_err_code <= w_ev_code;
                    r_err_pc   <= w_ev_pc;
                end
                r_fail <= 1'b1;
            end
            if (w_timeout) begin
                r_state <= ST_FAIL;
`ifdef TRACE_CHK_CONTINUE_EN
            end else if (w_head_end) begin
                r_state <= r_fail ? ST_FAIL : ST_PASS;
                r_pass  <= !r_fail;
            end
`else
            end else if (w_err) begin
                r_state <= ST_FAIL;
            end else if (w_head_end) begin
                r_state <= ST_PASS;
                r_pass  <= 1'b1;
            end
`endif
        end
    end

    assign busy       = w_run;
    assign pass       = r_pass;
    assign fail       = r_fail;
    assign err_code   = r_err_code;
    assign err_pc     = r_err_pc;
    assign commit_cnt = r_commit_cnt;
    assign err_cnt    = r_err_cnt;

endmodule

// File: doc/cpu_trace_checker.md
Name: cpu_trace_checker

Overview:
- Synthesizable, parametrised CPU commit-trace checker for on-board (FPGA) and simulation use.
- Consumes reference trace entries from a valid/ready stream into an internal prefetch FIFO.
- Compares each one against the CPU commit signals: PC, RF write, memory write and memory read.
- Adds what a plain bench comparison lacks: branch/jump target checking, a commit watchdog, error coding, counters and a clean pass/fail status visible over AXI-lite mirror registers upstream.

Parameters:
XLEN, 32, datapath/PC/address/data width
RF_AW, 5, register-file address width
FIFO_DEPTH, 4, reference entry prefetch depth (power of 2, >=2)
TIMEOUT_CYC, 1024, max cycles between commits while RUN before timeout
CNT_W, 32, width of commit and error counters

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
start  in  1  pulse: IDLE->RUN, clears counters/status
ref_valid  in  1  reference entry valid
ref_ready  out  1  FIFO not full
ref_type  in  3  0 end-of-trace, 1 RF write, 2 mem write, 3 branch, 4 jump&link
ref_pc  in  XLEN  expected commit PC
ref_addr  in  XLEN  RF addr (low RF_AW bits) or mem addr
ref_data  in  XLEN  expected RF/mem write data
ref_mask  in  XLEN  bit-compare mask (types 1,2)
ref_strb  in  XLEN/8  expected write strobe
ref_new_pc  in  XLEN  expected next PC (types 3,4)
ref_mem_read  in  1  expected MemRead (type 1)
commit_valid  in  1  one instruction retires this cycle
commit_pc, commit_rf_wen, commit_rf_waddr, commit_rf_wdata  in  XLEN/1/RF_AW/XLEN  DUT commit values
commit_mem_wen, commit_mem_read, commit_mem_addr, commit_mem_wstrb, commit_mem_wdata  in  1/1/XLEN/XLEN/8/XLEN
busy  out  1  state==RUN
pass  out  1  sticky, end-of-trace reached with no error
fail  out  1  sticky, error detected
err_code  out  4  first error code
err_pc  out  XLEN  commit_pc of first error
commit_cnt  out  CNT_W  checked commits
err_cnt  out  CNT_W  mismatching commits

Behaviour:
- Reset: all outputs 0; state IDLE; FIFO empty; exp_pc_vld=0.
- States:
  - IDLE: ref_ready=0, commits ignored; start->RUN and clears counters, status and FIFO.
  - RUN: normal checking.
  - PASS / FAIL: terminal; start->RUN.
- FIFO: push on ref_valid&&ref_ready; pop on a checked commit or on an end-of-trace head; simultaneous push+pop when full is allowed.
- End-of-trace head (type 0): pop it; next cycle PASS, pass=1.
- Check, in RUN when commit_valid and head type 1..4. Comparison is combinational; the result is registered, so status appears the cycle after the commit. First failing rule in this order sets err_code:
  - 1 PC mismatch.
  - 6 exp_pc_vld and commit_pc != exp_pc.
  - 2 flags: type1 mem_wen must be 0; type2 {mem_wen,rf_wen,mem_read}=100; type3 =000; type4 =010.
  - 3 type1 with addr!=0: rf_wen!=1, mem_read!=ref_mem_read, waddr mismatch, or (wdata&mask) mismatch. Type1 with addr==0: error if rf_wen&&waddr!=0, or if !ref_mem_read&&mem_read.
  - 4 type2: mem_addr, wstrb or (wdata&mask) mismatch.
  - 5 type4: waddr or full wdata mismatch.
- exp_pc: types 3/4 set exp_pc=ref_new_pc, exp_pc_vld=1; any other checked commit clears exp_pc_vld.
- Code 8: commit_valid with FIFO empty (underflow).
- Code 9: head type 5..7.
- Code 7: watchdog counter resets on each commit and at start; reaching TIMEOUT_CYC in RUN with no commit raises timeout.
- Every checked commit increments commit_cnt; every error increments err_cnt. Both saturate at all-ones.
- On the first error: latch err_code and err_pc (0 for timeout); fail=1.
- Reset asserted mid-RUN: everything returns to reset values immediately (asynchronous).

Optional Feature:
- TRACE_CHK_CONTINUE_EN defined:
  - An error sets fail and err_cnt, but the state stays RUN and checking continues; err_code/err_pc keep the first error.
  - End-of-trace goes to FAIL if fail=1, else PASS.
  - Timeout is always terminal.
- Undefined: the first error enters FAIL; ref_ready=0 and commits are ignored thereafter.

Decomposition:
- trace_chk_pkg: trace type encodings (TR_END, TR_RF, TR_MEM, TR_BR, TR_JAL), error codes (ERR_NONE..ERR_BADTYPE), state encoding.
- Sub-module trace_chk_fifo: parametrised synchronous FIFO (width=packed entry, FIFO_DEPTH) with full/empty and same-cycle push/pop.

Test Plan:
- Push RF entry (pc 0x0, addr 5, data 0x1234, mask 0xFFFFFFFF), then end; commit pc 0x0, rf_wen=1, waddr 5, wdata 0x1234 -> next cycle commit_cnt=1; then pass=1, err_code=0.
- Type1 addr 0, rf_wen=1, waddr 0 -> no error; same entry with waddr 3 -> fail, err_code=3, err_pc=commit_pc.
- Branch entry pc 0x10, new_pc 0x40, then RF entry pc 0x40; DUT commits pc 0x10 then 0x14 -> err_code=1 (PC rule precedes target rule). Repeat with ref pc 0x14 -> err_code=6.
- Mem write entry addr 0x100, strb 0x3, data 0xAABB, mask 0x0000FFFF; DUT wdata 0x1234AABB -> pass; wstrb 0xF -> err_code=4.
- No commit for 1024 cycles in RUN -> fail, err_code=7, err_pc=0. Commit with FIFO empty -> err_code=8.
- Two mismatching commits, then end: with TRACE_CHK_CONTINUE_EN -> err_cnt=2, FAIL at end; without -> err_cnt=1, FAIL immediately, ref_ready=0.
